// File: rtl/block_transfer_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// block_transfer_sequencer_pkg : LDM/STM decode fields and sequencer states
// Revision: 1.0
// ==========================================================================
package block_transfer_sequencer_pkg;

  localparam logic [2:0] c_BLOCK_MODE = 3'b100;

  localparam int c_MODE_HI = 27;
  localparam int c_MODE_LO = 25;
  localparam int c_P_BIT   = 24;
  localparam int c_U_BIT   = 23;
  localparam int c_W_BIT   = 21;
  localparam int c_L_BIT   = 20;
  localparam int c_RN_HI   = 19;
  localparam int c_RN_LO   = 16;
  localparam int c_LIST_HI = 15;
  localparam int c_LIST_LO = 0;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SEQ  = 2'd1;
  localparam logic [1:0] c_ST_WBB  = 2'd2;

  // Addressing-mode and base context held for the whole sequence
  typedef struct packed {
    logic       p;
    logic       u;
    logic       w;
    logic       l;
    logic [3:0] rn;
  } bt_ctx_t;

endpackage
`default_nettype wire

// File: rtl/block_transfer_sequencer_if.sv
`default_nettype none
// ==========================================================================
// block_transfer_sequencer_if : ID-stage <-> block transfer sequencer bus
// Revision: 1.0
// ==========================================================================
interface block_transfer_sequencer_if #(
  parameter int ADDRESS_LEN = 32,
  parameter int OFFSET_W    = 8
);
  logic [ADDRESS_LEN-1:0] instruction;
  logic                   instr_valid;
  logic                   cond_pass;
  logic                   hazard;
  logic                   flush;
  logic                   freeze;
  logic                   busy;
  logic                   uop_valid;
  logic                   uop_load;
  logic [3:0]             uop_rn;
  logic [3:0]             uop_reg;
  logic [OFFSET_W-1:0]    uop_offset;
  logic                   uop_wb_base;
  logic                   uop_last;

  modport master (
    output instruction, instr_valid, cond_pass, hazard, flush,
    input  freeze, busy, uop_valid, uop_load, uop_rn, uop_reg,
           uop_offset, uop_wb_base, uop_last
  );

  modport slave (
    input  instruction, instr_valid, cond_pass, hazard, flush,
    output freeze, busy, uop_valid, uop_load, uop_rn, uop_reg,
           uop_offset, uop_wb_base, uop_last
  );
endinterface
`default_nettype wire

// File: rtl/block_transfer_sequencer_lowest_set_bit.sv
`default_nettype none
// ==========================================================================
// lowest_set_bit : 16-bit priority encoder, index of the least significant 1
// Revision: 1.0
// ==========================================================================
module lowest_set_bit (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        any_set_o
);

  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

  assign any_set_o = |vec_i;

endmodule
`default_nettype wire

// File: rtl/block_transfer_sequencer.sv
`default_nettype none
// ==========================================================================
// block_transfer_sequencer : splits LDM/STM into single-register micro-ops
// Revision: 1.0
// ==========================================================================
module block_transfer_sequencer
  import block_transfer_sequencer_pkg::*;
#(
  parameter int ADDRESS_LEN = 32,
  parameter int OFFSET_W    = 8
) (
  input logic                        clk,
  input logic                        rst,
  block_transfer_sequencer_if.slave  bus
);

  localparam logic [OFFSET_W-1:0] c_FOUR = OFFSET_W'(4);

  logic [1:0]          state_q, state_d;
  logic [15:0]         mask_q, mask_d;
  logic [OFFSET_W-1:0] acc_q, acc_d;
  bt_ctx_t             ctx_q, ctx_d;
  logic [4:0]          n_q, n_d;
  logic                wben_q, wben_d;

  logic [ADDRESS_LEN-1:0] w_instr;
  bt_ctx_t                w_dec;
  logic [15:0]            w_list;
  logic                   w_block;
  logic                   w_unused;
  logic [4:0]             w_count;
  logic [OFFSET_W-1:0]    w_n4;
  logic [OFFSET_W-1:0]    w_start_off;
  logic [OFFSET_W-1:0]    w_wb_n4;
  logic                   w_start;

  assign w_instr   = bus.instruction;
  assign w_block   = (w_instr[c_MODE_HI:c_MODE_LO] == c_BLOCK_MODE);
  assign w_dec.p   = w_instr[c_P_BIT];
  assign w_dec.u   = w_instr[c_U_BIT];
  assign w_dec.w   = w_instr[c_W_BIT];
  assign w_dec.l   = w_instr[c_L_BIT];
  assign w_dec.rn  = w_instr[c_RN_HI:c_RN_LO];
  assign w_list    = w_instr[c_LIST_HI:c_LIST_LO];
  assign w_unused  = ^{w_instr[31:28], w_instr[22]};

  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_count = w_count + {4'd0, w_list[i]};
    end
  end

  assign w_n4    = OFFSET_W'({w_count, 2'b00});
  assign w_wb_n4 = OFFSET_W'({n_q, 2'b00});

  // First-issued (lowest) address relative to Rn for each addressing mode
  always_comb begin
    case ({w_dec.p, w_dec.u})
      2'b01:   w_start_off = '0;
      2'b11:   w_start_off = c_FOUR;
      2'b00:   w_start_off = c_FOUR - w_n4;
      default: w_start_off = '0 - w_n4;
    endcase
  end

  assign w_start = rst & (state_q == c_ST_IDLE) & bus.instr_valid & w_block
                 & bus.cond_pass & ~bus.hazard & ~bus.flush & (|w_list);

  logic [3:0]  w_idx;
  logic        w_any;
  logic [15:0] w_rest;
  logic [3:0]  w_rest_idx_unused;
  logic        w_rest_any;

  assign w_rest = mask_q & (mask_q - 16'd1);

  lowest_set_bit u_lsb_cur (
    .vec_i     (mask_q),
    .idx_o     (w_idx),
    .any_set_o (w_any)
  );

  lowest_set_bit u_lsb_rest (
    .vec_i     (w_rest),
    .idx_o     (w_rest_idx_unused),
    .any_set_o (w_rest_any)
  );

  logic w_issue_seq;
  logic w_issue_wbb;
  logic w_valid;
  logic w_last;

  assign w_issue_seq = (state_q == c_ST_SEQ) & ~bus.hazard & ~bus.flush & w_any;
  assign w_issue_wbb = (state_q == c_ST_WBB) & ~bus.hazard & ~bus.flush;
  assign w_valid     = w_issue_seq | w_issue_wbb;
  assign w_last      = (w_issue_seq & ~w_rest_any & ~wben_q) | w_issue_wbb;

  always_comb begin
    bus.uop_valid   = w_valid;
    bus.uop_load    = w_issue_seq & ctx_q.l;
    bus.uop_rn      = w_valid ? ctx_q.rn : 4'd0;
    bus.uop_reg     = 4'd0;
    bus.uop_offset  = '0;
    bus.uop_wb_base = w_issue_wbb;
    bus.uop_last    = w_last;
    if (w_issue_seq) begin
      bus.uop_reg    = w_idx;
      bus.uop_offset = acc_q;
    end else if (w_issue_wbb) begin
      bus.uop_reg    = ctx_q.rn;
      bus.uop_offset = ctx_q.u ? w_wb_n4 : ('0 - w_wb_n4);
    end
  end

  // Freeze releases in the cycle the last micro-op issues so fetch resumes at that edge
  assign bus.freeze = w_start
                    | ((state_q != c_ST_IDLE) & ~bus.flush & ~(w_valid & w_last));
  assign bus.busy   = (state_q != c_ST_IDLE);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    ctx_d   = ctx_q;
    n_d     = n_q;
    wben_d  = wben_q;
    if (bus.flush) begin
      state_d = c_ST_IDLE;
      mask_d  = '0;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_start) begin
            state_d = c_ST_SEQ;
            mask_d  = w_list;
            acc_d   = w_start_off;
            ctx_d   = w_dec;
            n_d     = w_count;
            // A load that includes Rn keeps the loaded value instead of the writeback
            wben_d  = w_dec.w & ~(w_dec.l & w_list[w_dec.rn]);
          end
        end
        c_ST_SEQ: begin
          if (w_issue_seq) begin
            mask_d = w_rest;
            acc_d  = acc_q + c_FOUR;
            if (!w_rest_any) state_d = wben_q ? c_ST_WBB : c_ST_IDLE;
          end
        end
        c_ST_WBB: begin
          if (w_issue_wbb) state_d = c_ST_IDLE;
        end
        default: state_d = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= c_ST_IDLE;
      mask_q  <= '0;
      acc_q   <= '0;
      ctx_q   <= '0;
      n_q     <= '0;
      wben_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      ctx_q   <= ctx_d;
      n_q     <= n_d;
      wben_q  <= wben_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_transfer_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_block_transfer_sequencer : directed LDM/STM sequences against a queue model
// Revision: 1.0
// ==========================================================================
module tb_block_transfer_sequencer;

  logic clk;
  logic rst;

  block_transfer_sequencer_if #(.ADDRESS_LEN(32), .OFFSET_W(8)) bus ();

  block_transfer_sequencer #(.ADDRESS_LEN(32), .OFFSET_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [3:0] rn;
    logic [3:0] rg;
    logic [7:0] off;
    logic       wb;
    logic       last;
  } uop_t;

  uop_t m_q[$];
  logic m_busy = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [31:0] I_LDMIA   = 32'hE8B0000A;
  localparam logic [31:0] I_STMDB   = 32'hE92D0070;
  localparam logic [31:0] I_LDMRN   = 32'hE8B20024;
  localparam logic [31:0] I_EMPTY   = 32'hE8900000;
  localparam logic [31:0] I_LDMIB   = 32'hE9910015;
  localparam logic [31:0] I_STMDA   = 32'hE8230180;
  localparam logic [31:0] I_LDMFULL = 32'hE8BDFFFF;
  localparam logic [31:0] I_STMFULL = 32'hE900FFFF;
  localparam logic [31:0] I_ADD     = 32'hE0810002;

  // Expected micro-op list from ARM block-transfer addressing rules
  task automatic build_queue(input logic [31:0] ins);
    logic p, u, w, l, wbe;
    logic [3:0] rn;
    logic [15:0] lst;
    int n, first, k;
    uop_t e;
    p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20];
    rn = ins[19:16]; lst = ins[15:0];
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    first = u ? (p ? 4 : 0) : (p ? -4 * n : -4 * n + 4);
    wbe = w && !(l && lst[rn]);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        e.load = l; e.rn = rn; e.rg = 4'(i); e.off = 8'(first + 4 * k);
        e.wb = 1'b0; e.last = (k == n - 1) && !wbe;
        m_q.push_back(e);
        k++;
      end
    end
    if (wbe) begin
      e.load = 1'b0; e.rn = rn; e.rg = rn; e.off = 8'(u ? 4 * n : -4 * n);
      e.wb = 1'b1; e.last = 1'b1;
      m_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] act, exp;
    logic st;
    uop_t u;
    if (!rst) begin
      m_busy = 1'b0;
      m_q.delete();
    end else begin
      st = 1'b0;
      if (bus.flush) begin
        exp = {1'b0, m_busy, 20'd0};
      end else if (!m_busy) begin
        st = bus.instr_valid && (bus.instruction[27:25] == 3'b100) && bus.cond_pass
             && !bus.hazard && (bus.instruction[15:0] != 16'd0);
        exp = {st, 21'd0};
      end else if (bus.hazard || m_q.size() == 0) begin
        exp = {2'b11, 20'd0};
      end else begin
        u = m_q[0];
        exp = {~u.last, 1'b1, 1'b1, u.load, u.rn, u.rg, u.off, u.wb, u.last};
      end
      act = {bus.freeze, bus.busy, bus.uop_valid, bus.uop_load, bus.uop_rn, bus.uop_reg,
             bus.uop_offset, bus.uop_wb_base, bus.uop_last};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL cycle_model t=%0t got fz/bz/v/ld/rn/rg/off/wb/last=%h required=%h",
                    $time, act, exp);
      if (bus.flush) begin
        m_busy = 1'b0;
        m_q.delete();
      end else if (st) begin
        build_queue(bus.instruction);
        m_busy = 1'b1;
      end else if (m_busy && !bus.hazard && m_q.size() != 0) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic cp,
                       input logic hz, input logic fl, input logic r);
    @(posedge clk);
    #1;
    bus.instruction = ins;
    bus.instr_valid = v;
    bus.cond_pass   = cp;
    bus.hazard      = hz;
    bus.flush       = fl;
    rst             = r;
    @(negedge clk);
    #1;
  endtask

  task automatic bubble();
    drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run(input logic [31:0] ins);
    drive(ins, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40 && m_busy; k++) drive(ins, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("run_terminates", {31'd0, m_busy}, 32'd0);
    bubble();
  endtask

  function automatic logic [31:0] outs_all();
    return {10'd0, bus.freeze, bus.busy, bus.uop_valid, bus.uop_load, bus.uop_rn,
            bus.uop_reg, bus.uop_offset, bus.uop_wb_base, bus.uop_last};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] fz;
    rst = 1'b0;
    bus.instruction = 32'd0; bus.instr_valid = 1'b0; bus.cond_pass = 1'b0;
    bus.hazard = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    bubble();
    chk("reset_outputs", outs_all(), 32'd0);

    // LDMIA r0!,{r1,r3}
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("ldmia_c0_freeze", {31'd0, bus.freeze}, 32'd1);
    chk("ldmia_c0_valid", {31'd0, bus.uop_valid}, 32'd0);
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("ldmia_c1_reg", {28'd0, bus.uop_reg}, 32'd1);
    chk("ldmia_c1_off", {24'd0, bus.uop_offset}, 32'd0);
    chk("ldmia_c1_load", {31'd0, bus.uop_load}, 32'd1);
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("ldmia_c2_reg", {28'd0, bus.uop_reg}, 32'd3);
    chk("ldmia_c2_off", {24'd0, bus.uop_offset}, 32'd4);
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("ldmia_c3_wb", {31'd0, bus.uop_wb_base}, 32'd1);
    chk("ldmia_c3_off", {24'd0, bus.uop_offset}, 32'd8);
    chk("ldmia_c3_last", {31'd0, bus.uop_last}, 32'd1);
    chk("ldmia_c3_freeze", {31'd0, bus.freeze}, 32'd0);
    bubble();
    chk("ldmia_idle", {31'd0, bus.busy}, 32'd0);

    // STMDB sp!,{r4-r6}
    for (int c = 0; c < 5; c++) begin
      drive(I_STMDB, 1, 1, 0, 0, 1);
      fz[4-c] = bus.freeze;
      if (c == 1) begin
        chk("stmdb_c1_reg", {28'd0, bus.uop_reg}, 32'd4);
        chk("stmdb_c1_off", {24'd0, bus.uop_offset}, 32'h000000F4);
      end
      if (c == 4) begin
        chk("stmdb_c4_wb_rn", {27'd0, bus.uop_wb_base, bus.uop_rn}, 32'h0000001D);
        chk("stmdb_c4_off", {24'd0, bus.uop_offset}, 32'h000000F4);
      end
    end
    chk("stmdb_freeze_pattern", {27'd0, fz}, 32'h0000001E);
    bubble();

    // LDMIA r2!,{r2,r5}: writeback suppressed
    drive(I_LDMRN, 1, 1, 0, 0, 1);
    drive(I_LDMRN, 1, 1, 0, 0, 1);
    drive(I_LDMRN, 1, 1, 0, 0, 1);
    chk("ldmrn_last_reg", {28'd0, bus.uop_reg}, 32'd5);
    chk("ldmrn_last", {30'd0, bus.uop_last, bus.uop_wb_base}, 32'd2);
    bubble();
    chk("ldmrn_no_wbb", {31'd0, bus.busy}, 32'd0);

    // Hazard mid-sequence and before the writeback
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("hz_c1_reg", {28'd0, bus.uop_reg}, 32'd1);
    for (int c = 0; c < 2; c++) begin
      drive(I_LDMIA, 1, 1, 1, 0, 1);
      chk("hz_hold", {30'd0, bus.uop_valid, bus.freeze}, 32'd1);
    end
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("hz_resume_reg_off", {20'd0, bus.uop_reg, bus.uop_offset}, 32'h304);
    drive(I_LDMIA, 1, 1, 1, 0, 1);
    chk("hz_wbb_hold", {30'd0, bus.uop_valid, bus.freeze}, 32'd1);
    drive(I_LDMIA, 1, 1, 0, 0, 1);
    chk("hz_wbb_off", {23'd0, bus.uop_wb_base, bus.uop_offset}, 32'h108);
    bubble();

    // Flush during C2 of STMDB
    drive(I_STMDB, 1, 1, 0, 0, 1);
    drive(I_STMDB, 1, 1, 0, 0, 1);
    drive(I_STMDB, 1, 1, 0, 1, 1);
    chk("flush_kill", {30'd0, bus.uop_valid, bus.freeze}, 32'd0);
    bubble();
    chk("flush_idle", {31'd0, bus.busy}, 32'd0);
    run(I_LDMIA);

    // Empty list, failed condition, hazard blocking start, non-block instruction
    drive(I_EMPTY, 1, 1, 0, 0, 1);
    chk("empty_list", {30'd0, bus.freeze, bus.uop_valid}, 32'd0);
    bubble();
    chk("empty_idle", {31'd0, bus.busy}, 32'd0);
    drive(I_LDMIA, 1, 0, 0, 0, 1);
    chk("cond_fail", {31'd0, bus.freeze}, 32'd0);
    bubble();
    chk("cond_idle", {31'd0, bus.busy}, 32'd0);
    drive(I_LDMIA, 1, 1, 1, 0, 1);
    chk("hazard_no_start", {31'd0, bus.freeze}, 32'd0);
    run(I_LDMIA);
    run(I_ADD);

    // Reset mid-sequence
    drive(I_STMDB, 1, 1, 0, 0, 1);
    drive(I_STMDB, 1, 1, 0, 0, 1);
    drive(I_STMDB, 1, 1, 0, 0, 0);
    bubble();
    chk("midseq_reset", outs_all(), 32'd0);

    run(I_STMDB);
    run(I_LDMIB);
    run(I_STMDA);
    run(I_LDMFULL);
    run(I_STMFULL);
    run(I_LDMRN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
